// File: rtl/test_scoreboard.sv
// Result collector for the self-check harness: owns the run cycle counter, latches
// first-arrival verdicts, detects completion/timeout and replays a per-test summary stream.
module test_scoreboard #(
   parameter int unsigned num_tests = 18,
   parameter int unsigned timeout   = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   output logic [31:0]          cycles,
   input  logic [num_tests-1:0] res_valid,
   input  logic [num_tests-1:0] res_pass,
   output logic                 busy,
   output logic                 done,
   output logic                 all_pass,
   output logic                 timed_out,
   output logic [7:0]           pass_count,
   output logic [7:0]           fail_count,
   output logic                 rep_valid,
   input  logic                 rep_ready,
   output logic [7:0]           rep_id,
   output logic [1:0]           rep_status
);

   localparam logic [31:0] TimeoutC = 32'(timeout);
   localparam logic [7:0]  LastId   = 8'(num_tests - 1);

   typedef enum logic [1:0] {StIdle, StRun, StReport, StDone} state_e;

   state_e               state;
   logic [num_tests-1:0] seen;
   logic [num_tests-1:0] passed;
   logic [num_tests-1:0] new_bits;
   logic [num_tests-1:0] seen_next;
   logic [num_tests-1:0] pass_next;
   logic                 complete;

   function automatic logic [7:0] popcount(input logic [num_tests-1:0] v);
      logic [7:0] cnt;
      cnt = 8'd0;
      for (int i = 0; i < int'(num_tests); i++) begin
         cnt = cnt + 8'(v[i]);
      end
      return cnt;
   endfunction

   function automatic logic [1:0] status_of(input logic [num_tests-1:0] s,
                                            input logic [num_tests-1:0] p,
                                            input logic [7:0]           idx);
      logic [num_tests-1:0] sh_s;
      logic [num_tests-1:0] sh_p;
      sh_s = s >> idx;
      sh_p = p >> idx;
      if (!sh_s[0]) return 2'b00;
      return sh_p[0] ? 2'b01 : 2'b10;
   endfunction

   // Only the first strobe per test counts; later ones are masked by seen.
   always_comb begin
      new_bits  = res_valid & ~seen;
      seen_next = seen | res_valid;
      pass_next = passed | (new_bits & res_pass);
      complete  = &seen_next;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= StIdle;
         seen       <= '0;
         passed     <= '0;
         cycles     <= 32'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         all_pass   <= 1'b0;
         timed_out  <= 1'b0;
         pass_count <= 8'd0;
         fail_count <= 8'd0;
         rep_valid  <= 1'b0;
         rep_id     <= 8'd0;
         rep_status <= 2'b00;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  state      <= StRun;
                  seen       <= '0;
                  passed     <= '0;
                  cycles     <= 32'd0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  all_pass   <= 1'b0;
                  timed_out  <= 1'b0;
                  pass_count <= 8'd0;
                  fail_count <= 8'd0;
                  rep_id     <= 8'd0;
                  rep_status <= 2'b00;
               end
            end
            StRun: begin
               seen       <= seen_next;
               passed     <= pass_next;
               pass_count <= pass_count + popcount(new_bits & res_pass);
               fail_count <= fail_count + popcount(new_bits & ~res_pass);
               // cycles stays at its final RUN value once the run ends
               if (complete || (cycles == TimeoutC)) begin
                  state      <= StReport;
                  timed_out  <= !complete;
                  rep_valid  <= 1'b1;
                  rep_id     <= 8'd0;
                  rep_status <= status_of(seen_next, pass_next, 8'd0);
               end else begin
                  cycles <= cycles + 32'd1;
               end
            end
            StReport: begin
               if (rep_ready) begin
                  if (rep_id == LastId) begin
                     state      <= StDone;
                     rep_valid  <= 1'b0;
                     rep_status <= 2'b00;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     all_pass   <= (fail_count == 8'd0) && !timed_out;
                  end else begin
                     rep_id     <= rep_id + 8'd1;
                     rep_status <= status_of(seen, passed, rep_id + 8'd1);
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_test_scoreboard.sv
// Directed bench for test_scoreboard: expected report entries are queued at stimulus time
// and a negedge monitor pops and compares each accepted entry.
module tb_test_scoreboard;

   localparam int unsigned N  = 18;
   localparam int unsigned TO = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [N-1:0]  res_valid = '0;
   logic [N-1:0]  res_pass = '0;
   logic          rep_ready = 1'b1;
   logic [31:0]   cycles;
   logic          busy, done, all_pass, timed_out, rep_valid;
   logic [7:0]    pass_count, fail_count, rep_id;
   logic [1:0]    rep_status;

   test_scoreboard #(.num_tests(N), .timeout(TO)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .cycles     (cycles),
      .res_valid  (res_valid),
      .res_pass   (res_pass),
      .busy       (busy),
      .done       (done),
      .all_pass   (all_pass),
      .timed_out  (timed_out),
      .pass_count (pass_count),
      .fail_count (fail_count),
      .rep_valid  (rep_valid),
      .rep_ready  (rep_ready),
      .rep_id     (rep_id),
      .rep_status (rep_status)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] id;
      logic [1:0] st;
   } entry_t;

   entry_t exp_q[$];
   int     n_checks = 0;
   int     n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: pops on each accepted entry, checks stability while stalled.
   logic   held = 1'b0;
   entry_t held_e;
   entry_t mon_e;
   always @(negedge clock) begin
      if (rep_valid) begin
         if (held) check("rep_hold", 32'({rep_id, rep_status}), 32'(held_e));
         if (rep_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL rep_unexpected: got id %0d status %0d, none expected",
                        rep_id, rep_status);
            end else begin
               mon_e = exp_q.pop_front();
               check("rep_id", 32'(rep_id), 32'(mon_e.id));
               check("rep_status", 32'(rep_status), 32'(mon_e.st));
            end
            held = 1'b0;
         end else begin
            held   = 1'b1;
            held_e = {rep_id, rep_status};
         end
      end else begin
         held = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic tick_to(input logic [31:0] n);
      int g = 0;
      while (cycles != n && g < 100) begin
         tick();
         g++;
      end
      check("reach_cycles", cycles, n);
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_cycles", cycles, 32'd0);
   endtask

   task automatic push_exp(input logic [N-1:0] v, input logic [N-1:0] p);
      entry_t e;
      for (int i = 0; i < int'(N); i++) begin
         e.id = 8'(i);
         e.st = !v[i] ? 2'b00 : (p[i] ? 2'b01 : 2'b10);
         exp_q.push_back(e);
      end
   endtask

   task automatic finish_report(input logic exp_ap, input logic exp_to);
      int g = 0;
      while (!done && g < 200) begin
         tick();
         g++;
      end
      check("done", 32'(done), 32'd1);
      check("all_pass", 32'(all_pass), 32'(exp_ap));
      check("timed_out", 32'(timed_out), 32'(exp_to));
      check("done_rep_valid", 32'(rep_valid), 32'd0);
      check("done_busy", 32'(busy), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int g;
      // Reset state
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cycles", cycles, 32'd0);
      check("rst_pass_count", 32'(pass_count), 32'd0);
      check("rst_fail_count", 32'(fail_count), 32'd0);
      check("rst_rep_valid", 32'(rep_valid), 32'd0);
      check("rst_all_pass", 32'(all_pass), 32'd0);
      check("rst_timed_out", 32'(timed_out), 32'd0);
      reset = 1'b1;
      tick();

      // Reset mid-run
      start_run();
      tick_to(32'd1);
      res_valid = 18'h0001f;
      res_pass  = 18'h0001f;
      tick();
      res_valid = '0;
      res_pass  = '0;
      check("mid_pass_count", 32'(pass_count), 32'd5);
      tick_to(32'd4);
      #1 reset = 1'b0;
      #1;
      check("async_busy", 32'(busy), 32'd0);
      check("async_cycles", cycles, 32'd0);
      check("async_pass_count", 32'(pass_count), 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // All pass together at cycles=3
      start_run();
      tick_to(32'd3);
      push_exp('1, '1);
      res_valid = '1;
      res_pass  = '1;
      tick();
      res_valid = '0;
      res_pass  = '0;
      check("all_pass_count", 32'(pass_count), 32'd18);
      check("all_fail_count", 32'(fail_count), 32'd0);
      check("all_rep_valid", 32'(rep_valid), 32'd1);
      check("all_rep_id0", 32'(rep_id), 32'd0);
      repeat (17) tick();
      check("all_last_id", 32'(rep_id), 32'd17);
      check("all_not_done", 32'(done), 32'd0);
      tick();
      finish_report(1'b1, 1'b0);
      check("all_cycles_frozen", cycles, 32'd3);

      // Mixed verdicts, tests 5 and 9 fail, strobed on different cycles
      start_run();
      tick_to(32'd1);
      push_exp('1, 18'h3fddf);
      res_valid = 18'h001ff;
      res_pass  = 18'h001df;
      tick();
      res_valid = 18'h3fe00;
      res_pass  = 18'h3fc00;
      tick();
      res_valid = '0;
      res_pass  = '0;
      check("mix_pass_count", 32'(pass_count), 32'd16);
      check("mix_fail_count", 32'(fail_count), 32'd2);
      check("mix_rep_valid", 32'(rep_valid), 32'd1);
      finish_report(1'b0, 1'b0);

      // Duplicate strobe on test 2, then backpressure on entry 4
      start_run();
      tick_to(32'd1);
      res_valid = 18'h00004;
      res_pass  = 18'h00004;
      tick();
      res_pass  = '0;
      tick();
      res_valid = '0;
      check("dup_pass_count", 32'(pass_count), 32'd1);
      check("dup_fail_count", 32'(fail_count), 32'd0);
      push_exp('1, '1);
      res_valid = '1;
      res_pass  = ~18'h00004;
      tick();
      res_valid = '0;
      res_pass  = '0;
      check("dup_final_pass", 32'(pass_count), 32'd18);
      check("dup_final_fail", 32'(fail_count), 32'd0);
      g = 0;
      while (rep_id != 8'd4 && g < 20) begin
         tick();
         g++;
      end
      check("bp_reach_id4", 32'(rep_id), 32'd4);
      rep_ready = 1'b0;
      repeat (3) begin
         tick();
         check("bp_id_stable", 32'(rep_id), 32'd4);
         check("bp_status_stable", 32'(rep_status), 32'd1);
      end
      rep_ready = 1'b1;
      finish_report(1'b1, 1'b0);

      // Timeout with tests 16,17 missing; start ignored mid-run
      start_run();
      tick_to(32'd1);
      push_exp(18'h0ffff, 18'h0ffff);
      res_valid = 18'h0ffff;
      res_pass  = 18'h0ffff;
      tick();
      res_valid = '0;
      res_pass  = '0;
      tick_to(32'd10);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_ignored", cycles, 32'd11);
      tick_to(32'd32);
      check("to_not_yet", 32'(timed_out), 32'd0);
      check("to_not_report", 32'(rep_valid), 32'd0);
      tick();
      check("to_timed_out", 32'(timed_out), 32'd1);
      check("to_rep_valid", 32'(rep_valid), 32'd1);
      check("to_cycles", cycles, 32'd32);
      check("to_pass_count", 32'(pass_count), 32'd16);
      finish_report(1'b0, 1'b1);

      // Strobes outside RUN are ignored
      res_valid = '1;
      res_pass  = '0;
      tick();
      res_valid = '0;
      check("idle_strobe_fail", 32'(fail_count), 32'd0);
      check("idle_strobe_pass", 32'(pass_count), 32'd16);

      // Completing strobe exactly at cycles==timeout
      start_run();
      tick_to(32'd32);
      push_exp('1, '1);
      res_valid = '1;
      res_pass  = '1;
      tick();
      res_valid = '0;
      res_pass  = '0;
      check("edge_timed_out", 32'(timed_out), 32'd0);
      check("edge_pass_count", 32'(pass_count), 32'd18);
      check("edge_rep_valid", 32'(rep_valid), 32'd1);
      finish_report(1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/test_scoreboard.md
# test_scoreboard

Result collector for the primitive self-check harness. It owns the run's cycle counter and receives one pass/fail strobe per test instance. It latches first-arrival outcomes and detects completion or timeout. It then replays a per-test summary over a valid/ready stream to the log or host side. It replaces the ad-hoc cycle counter and fixed-cycle finish in the harness top, and is the receiving end of every test's verdict.

## Interface
- num_tests, 18, number of test instances reporting; legal range 1..255
- timeout, 32, cycle budget for a run, counted on cycles
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset asserted); deassertion synchronous to clock externally
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- cycles  out  32  cycles elapsed since entering RUN; driven to all test instances
- res_valid  in  num_tests  per-test verdict strobe
- res_pass  in  num_tests  verdict, qualified by the matching res_valid bit
- busy  out  1  high in RUN and REPORT
- done  out  1  high in DONE
- all_pass  out  1  done && fail_count==0 && !timed_out
- timed_out  out  1  run ended by timeout with tests missing
- pass_count  out  8  tests latched as pass
- fail_count  out  8  tests latched as fail
- rep_valid  out  1  summary entry valid
- rep_ready  in  1  summary entry accepted when rep_valid && rep_ready
- rep_id  out  8  test index of current entry
- rep_status  out  2  00 missing, 01 pass, 10 fail; 11 never driven

## Operation
- States: IDLE, RUN, REPORT, DONE. Reset forces IDLE.
- Reset values: all outputs 0 and all latched verdicts cleared.
- IDLE: when start=1, go to RUN. Clear the seen and pass bit vectors, counts, cycles and timed_out.
- DONE: start=1 behaves as in IDLE. Outputs hold until then.
- start is ignored in RUN and REPORT.
- RUN, cycles: increments by 1 every cycle (wraps modulo 2^32; unreachable for legal timeout).
- RUN, per-test latch: test i latches only on its first res_valid[i]. Set seen[i] and store res_pass[i].
- RUN, later strobes: further strobes for test i are ignored, including ones with a conflicting verdict.
- RUN, counts: pass_count and fail_count add the popcount of newly latched pass and fail bits that cycle. Several simultaneous strobes are all counted.
- RUN exit, completion: when seen, including strobes sampled this cycle, becomes all-ones, go to REPORT.
- RUN exit, timeout: when cycles==timeout and seen is not all-ones after this cycle's strobes, go to REPORT and set timed_out.
- Strobes outside RUN are ignored.
- REPORT: present entries in order for rep_id = 0..num_tests-1.
  - rep_status = 00 if !seen, 01 if pass, 10 if fail.
  - rep_valid is high throughout REPORT.
  - rep_id and rep_status hold stable until accepted.
  - Acceptance of the last entry goes to DONE.
- cycles freezes at its last RUN value during REPORT and DONE. It is cleared on the next start.

## Timing
- start sampled at edge t: busy=1 and cycles=0 from t+1.
- cycles=n in the n-th RUN cycle, counting from 0.
- A strobe sampled at edge k is reflected in the counts from k+1.
- Completing strobe at edge k: REPORT from k+1, with rep_valid=1 and rep_id=0 in that cycle.
- Timeout: REPORT and timed_out=1 in the cycle after cycles==timeout.
- A strobe arriving in the cycle where cycles==timeout is counted. If it completes the set, timed_out stays 0.
- REPORT throughput: one entry per cycle with rep_ready held high. Minimum REPORT length is num_tests cycles.
- done=1 the cycle after the final acceptance. rep_valid=0 and busy=0 at the same time.
- Asynchronous reset mid-RUN or mid-REPORT: all outputs 0 immediately, without waiting for clock. State is IDLE after release.

## Test plan
- Reset mid-run: start, strobe 5 tests passing, assert reset at cycles=4 → immediately busy=0, cycles=0, pass_count=0. After release, the next start runs cleanly.
- All pass together: all 18 strobe res_pass=1 at cycles=3 → pass_count=18 next cycle, then REPORT. Expect 18 entries, status 01, ids 0..17, then done=1, all_pass=1.
- Mixed verdicts: tests 5 and 9 fail, others pass, strobed on different cycles → fail_count=2, pass_count=16. Entries 5 and 9 have status 10. all_pass=0.
- Timeout: tests 0..15 report and tests 16,17 never do; timeout=32 → REPORT after cycles=32, timed_out=1. Entries 16,17 have status 00. all_pass=0.
- Backpressure: hold rep_ready=0 for 3 cycles on entry 4 → rep_id=4 and rep_status stable for all 4 cycles. No entry skipped or duplicated.
- Duplicate strobe: test 2 passes at cycles=1, then strobes fail at cycles=2 → pass_count unchanged, fail_count unchanged. Entry 2 status 01.
